// File: rtl/core_pkg.sv
// Shared encodings for multicycle_core: RV32I subset opcodes/functs and FSM states.
package core_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_LSW = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;

endpackage

// File: rtl/regfile.sv
// Architectural register file: two async read ports, one sync write port, x0 hardwired to zero.
module regfile #(
  parameter int unsigned WORD_LEN  = 32,
  parameter int unsigned REG_COUNT = 32,
  localparam int unsigned AW = $clog2(REG_COUNT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       ra1_i,
  input  logic [AW-1:0]       ra2_i,
  output logic [WORD_LEN-1:0] rd1_o,
  output logic [WORD_LEN-1:0] rd2_o,
  input  logic                we_i,
  input  logic [AW-1:0]       wa_i,
  input  logic [WORD_LEN-1:0] wd_i
);

  logic [WORD_LEN-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/multicycle_core.sv
// Multicycle RV32I-subset core (LW, SW, ADD, SUB, ADDI, BEQ) with FETCH/EXEC/MEM/HALT FSM
// and valid/ready style instruction and data memory handshakes.
module multicycle_core
  import core_pkg::*;
#(
  parameter int unsigned         WORD_LEN  = 32,
  parameter int unsigned         REG_COUNT = 32,
  parameter logic [WORD_LEN-1:0] RESET_PC  = '0,
  parameter logic [WORD_LEN-1:0] EXIT_PC   = WORD_LEN'(8)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                exit,
  output logic                trap,
  output logic                retire,
  output logic                imem_req,
  output logic [WORD_LEN-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [WORD_LEN-1:0] imem_rdata,
  output logic                dmem_req,
  output logic                dmem_wen,
  output logic [WORD_LEN-1:0] dmem_addr,
  output logic [WORD_LEN-1:0] dmem_wdata,
  input  logic                dmem_ready,
  input  logic [WORD_LEN-1:0] dmem_rdata
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  state_e              state_q;
  logic [WORD_LEN-1:0] pc_q, addr_q, wdata_q;
  logic [31:0]         ir_q;
  logic                wen_q, exit_q, trap_q, retire_q;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic       is_lw, is_sw, is_add, is_sub, is_addi, is_beq, is_alu, mem_op;
  logic       taken, exec_trap, rf_we;
  logic [WORD_LEN-1:0] rs1_d, rs2_d, imm_i, imm_s, imm_b;
  logic [WORD_LEN-1:0] pc_inc, br_tgt, ea, alu_res, wb_data;

  assign opc = ir_q[6:0];
  assign f3  = ir_q[14:12];
  assign f7  = ir_q[31:25];

  assign is_lw   = opc == OPC_LOAD   && f3 == F3_LSW;
  assign is_sw   = opc == OPC_STORE  && f3 == F3_LSW;
  assign is_add  = opc == OPC_OP     && f3 == F3_ADD && f7 == F7_ADD;
  assign is_sub  = opc == OPC_OP     && f3 == F3_ADD && f7 == F7_SUB;
  assign is_addi = opc == OPC_OPIMM  && f3 == F3_ADD;
  assign is_beq  = opc == OPC_BRANCH && f3 == F3_BEQ;
  assign is_alu  = is_add | is_sub | is_addi;
  assign mem_op  = is_lw | is_sw;

  assign imm_i = {{(WORD_LEN-12){ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{(WORD_LEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{(WORD_LEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};

  assign pc_inc  = pc_q + WORD_LEN'(4);
  assign br_tgt  = pc_q + imm_b;
  assign ea      = rs1_d + (is_sw ? imm_s : imm_i);
  assign taken   = rs1_d == rs2_d;
  assign alu_res = is_add ? rs1_d + rs2_d : is_sub ? rs1_d - rs2_d : rs1_d + imm_i;

  // Unknown encodings and misaligned data/branch targets all stop the core before any side effect.
  assign exec_trap = !(is_alu || is_beq || mem_op)
                   || (mem_op && ea[1:0] != 2'b00)
                   || (is_beq && taken && br_tgt[1:0] != 2'b00);

  assign rf_we   = (state_q == EXEC && is_alu) || (state_q == MEM && dmem_ready && !wen_q);
  assign wb_data = (state_q == MEM) ? dmem_rdata : alu_res;

  regfile #(.WORD_LEN(WORD_LEN), .REG_COUNT(REG_COUNT)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (ir_q[15 +: AW]),
    .ra2_i (ir_q[20 +: AW]),
    .rd1_o (rs1_d),
    .rd2_o (rs2_d),
    .we_i  (rf_we),
    .wa_i  (ir_q[7 +: AW]),
    .wd_i  (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wen_q    <= 1'b0;
      exit_q   <= 1'b0;
      trap_q   <= 1'b0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        FETCH: begin
          if (pc_q == EXIT_PC) begin
            state_q <= HALT;
            exit_q  <= 1'b1;
          end else if (imem_ready) begin
            ir_q    <= imem_rdata[31:0];
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (exec_trap) begin
            state_q <= HALT;
            exit_q  <= 1'b1;
            trap_q  <= 1'b1;
          end else if (mem_op) begin
            addr_q  <= ea;
            wdata_q <= rs2_d;
            wen_q   <= is_sw;
            state_q <= MEM;
          end else begin
            pc_q     <= (is_beq && taken) ? br_tgt : pc_inc;
            retire_q <= 1'b1;
            state_q  <= FETCH;
          end
        end
        MEM: begin
          if (dmem_ready) begin
            pc_q     <= pc_inc;
            retire_q <= 1'b1;
            state_q  <= FETCH;
          end
        end
        default: state_q <= HALT;
      endcase
    end
  end

  assign exit       = exit_q;
  assign trap       = trap_q;
  assign retire     = retire_q;
  // Reset parks the FSM in FETCH at RESET_PC; rst masks the fetch request so it stays low while held.
  assign imem_req   = !rst && state_q == FETCH && pc_q != EXIT_PC;
  assign imem_addr  = pc_q;
  assign dmem_req   = state_q == MEM;
  assign dmem_wen   = wen_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboarded bench for multicycle_core: an ISA-level model predicts fetch/data traffic,
// retire count, cycle count and final state; a memory responder/monitor checks the live bus.
module tb_multicycle_core;

  typedef struct {
    bit          is_mem;
    logic [31:0] addr;
    bit          wen;
    logic [31:0] data;
  } ev_t;

  logic        clk, rst;
  logic        exit, trap, retire;
  logic        imem_req, imem_ready, dmem_req, dmem_wen, dmem_ready;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;

  logic [31:0] imem [1024];
  logic [31:0] dmem [1024];
  logic [31:0] rmem [1024];
  logic [31:0] rx   [32];
  ev_t         exp_q [$];

  int n_checks, n_fail, retire_cnt, iwait, dwait;
  int exp_cycles, exp_retire, last_cyc;
  bit exp_trap;

  multicycle_core #(.WORD_LEN(32), .REG_COUNT(32), .RESET_PC(32'd0), .EXIT_PC(32'd8)) dut (
    .clk(clk), .rst(rst), .exit(exit), .trap(trap), .retire(retire),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] sx12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  function automatic logic [31:0] e_i(input logic [11:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] e_r(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'h33};
  endfunction

  function automatic logic [31:0] e_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] e_b(input logic [12:0] off, input logic [4:0] rs2, input logic [4:0] rs1);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'h63};
  endfunction

  // ISA-level reference: walks the program, queues expected bus traffic, tallies cycles.
  task automatic model_run(input int iw, input int dw);
    logic [31:0] pc, npc, ins, a, b, ea, res;
    bit wr;
    for (int i = 0; i < 32; i++) rx[i] = '0;
    rmem = dmem;
    pc = 32'd0; exp_cycles = 0; exp_retire = 0; exp_trap = 0;
    for (int s = 0; s < 500; s++) begin
      if (pc == 32'd8) begin
        exp_cycles += 1;
        return;
      end
      ins = imem[pc[11:2]];
      exp_q.push_back('{is_mem: 1'b0, addr: pc, wen: 1'b0, data: ins});
      a = rx[ins[19:15]];
      b = rx[ins[24:20]];
      npc = pc + 32'd4; wr = 0; res = '0;
      if (ins[6:0] == 7'h13 && ins[14:12] == 3'b000) begin
        res = a + sx12(ins[31:20]); wr = 1; exp_cycles += 2 + iw;
      end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'b000 && ins[31:25] == 7'h00) begin
        res = a + b; wr = 1; exp_cycles += 2 + iw;
      end else if (ins[6:0] == 7'h33 && ins[14:12] == 3'b000 && ins[31:25] == 7'h20) begin
        res = a - b; wr = 1; exp_cycles += 2 + iw;
      end else if (ins[6:0] == 7'h63 && ins[14:12] == 3'b000) begin
        if (a == b) npc = pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        if (npc[1:0] != 2'b00) begin exp_cycles += 2 + iw; exp_trap = 1; return; end
        exp_cycles += 2 + iw;
      end else if (ins[6:0] == 7'h03 && ins[14:12] == 3'b010) begin
        ea = a + sx12(ins[31:20]);
        if (ea[1:0] != 2'b00) begin exp_cycles += 2 + iw; exp_trap = 1; return; end
        exp_q.push_back('{is_mem: 1'b1, addr: ea, wen: 1'b0, data: 32'd0});
        res = rmem[ea[11:2]]; wr = 1; exp_cycles += 3 + iw + dw;
      end else if (ins[6:0] == 7'h23 && ins[14:12] == 3'b010) begin
        ea = a + sx12({ins[31:25], ins[11:7]});
        if (ea[1:0] != 2'b00) begin exp_cycles += 2 + iw; exp_trap = 1; return; end
        exp_q.push_back('{is_mem: 1'b1, addr: ea, wen: 1'b1, data: b});
        rmem[ea[11:2]] = b; exp_cycles += 3 + iw + dw;
      end else begin
        exp_cycles += 2 + iw; exp_trap = 1; return;
      end
      if (wr && ins[11:7] != 5'd0) rx[ins[11:7]] = res;
      pc = npc;
      exp_retire++;
    end
  endtask

  // Memory responder + bus monitor, one pass per negedge so ready and checks see the same view.
  initial begin
    bit pi, pir, pd, pdr, pdwen;
    logic [31:0] pia, pda, pdw;
    int ic, dc;
    ev_t e;
    imem_ready = 0; dmem_ready = 0; imem_rdata = '0; dmem_rdata = '0;
    pi = 0; pir = 0; pd = 0; pdr = 0; pdwen = 0; pia = '0; pda = '0; pdw = '0; ic = 0; dc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ready = 0; dmem_ready = 0; ic = 0; dc = 0; pi = 0; pd = 0;
        continue;
      end
      if (pi && !pir) begin
        check("imem_hold_req", 32'(imem_req), 32'd1);
        check("imem_hold_addr", imem_addr, pia);
      end
      if (pd && !pdr) begin
        check("dmem_hold_req", 32'(dmem_req), 32'd1);
        check("dmem_hold_addr", dmem_addr, pda);
        check("dmem_hold_wen", 32'(dmem_wen), 32'(pdwen));
        check("dmem_hold_wdata", dmem_wdata, pdw);
      end
      check("req_exclusive", 32'(imem_req & dmem_req), 32'd0);
      if (imem_req) begin
        if (ic >= iwait) begin imem_ready = 1; imem_rdata = imem[imem_addr[11:2]]; ic = 0; end
        else begin imem_ready = 0; ic++; end
      end else begin
        imem_ready = ($urandom_range(0, 3) == 0); imem_rdata = $urandom;
      end
      if (dmem_req) begin
        if (dc >= dwait) begin
          dmem_ready = 1; dmem_rdata = dmem[dmem_addr[11:2]]; dc = 0;
          if (dmem_wen) dmem[dmem_addr[11:2]] = dmem_wdata;
        end else begin dmem_ready = 0; dc++; end
      end else begin
        dmem_ready = ($urandom_range(0, 3) == 0); dmem_rdata = $urandom;
      end
      if (imem_req && imem_ready) begin
        check("fetch_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("fetch_kind", 32'(e.is_mem), 32'd0);
          check("fetch_addr", imem_addr, e.addr);
        end
      end
      if (dmem_req && dmem_ready) begin
        check("dmem_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("dmem_kind", 32'(e.is_mem), 32'd1);
          check("dmem_addr", dmem_addr, e.addr);
          check("dmem_wen", 32'(dmem_wen), 32'(e.wen));
          if (e.wen) check("dmem_wdata", dmem_wdata, e.data);
        end
      end
      if (retire) retire_cnt++;
      pi = imem_req; pir = imem_ready; pia = imem_addr;
      pd = dmem_req; pdr = dmem_ready; pda = dmem_addr; pdw = dmem_wdata; pdwen = dmem_wen;
    end
  end

  task automatic launch(input int iw, input int dw);
    @(negedge clk);
    #1 rst = 1;
    #1;
    check("rst_exit", 32'(exit), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_retire", 32'(retire), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    iwait = iw; dwait = dw;
    repeat (2) @(posedge clk);
    exp_q.delete();
    retire_cnt = 0;
    model_run(iw, dw);
    @(posedge clk);
    #2 rst = 0;
  endtask

  task automatic finish_run(input string tag);
    int cyc;
    cyc = 0;
    while (exit !== 1'b1 && cyc < 3000) begin
      @(posedge clk); #1; cyc++;
    end
    last_cyc = cyc;
    check({tag, "_exit"}, 32'(exit), 32'd1);
    check({tag, "_cycles"}, cyc, exp_cycles);
    check({tag, "_trap"}, 32'(trap), 32'(exp_trap));
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_exit_held"}, 32'(exit), 32'd1);
    check({tag, "_retires"}, retire_cnt, exp_retire);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    for (int i = 0; i < 32; i++) check($sformatf("%s_x%0d", tag, i), dut.u_rf.regs_q[i], rx[i]);
    for (int w = 64; w < 128; w++) check($sformatf("%s_mem%0h", tag, w * 4), dmem[w], rmem[w]);
  endtask

  task automatic run_prog(input string tag, input int iw, input int dw);
    launch(iw, dw);
    finish_run(tag);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 32'hFFFF_FFFF;
  endtask

  task automatic gen_random(input int n);
    int p;
    logic [4:0] rd, r1, r2;
    clear_imem();
    imem[0] = e_b(13'd64, 5'd0, 5'd0);
    p = 16;
    for (int k = 0; k < n; k++) begin
      rd = 5'($urandom_range(0, 7)); r1 = 5'($urandom_range(0, 7)); r2 = 5'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: imem[p] = e_i(12'($urandom), r1, 3'b000, rd, 7'h13);
        1: imem[p] = e_r(7'h00, r2, r1, rd);
        2: imem[p] = e_r(7'h20, r2, r1, rd);
        3: imem[p] = e_i(12'(32'h100 + 4 * $urandom_range(0, 63)), 5'd0, 3'b010, rd, 7'h03);
        4: imem[p] = e_s(12'(32'h100 + 4 * $urandom_range(0, 63)), r2, 5'd0);
        default: imem[p] = e_b(13'(4 * $urandom_range(1, 2)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      endcase
      p++;
    end
    imem[p]     = e_b(13'(8 - 4 * p), 5'd0, 5'd0);
    imem[p + 1] = e_b(13'(8 - 4 * (p + 1)), 5'd0, 5'd0);
  endtask

  initial begin
    bit found;
    rst = 1; n_checks = 0; n_fail = 0; retire_cnt = 0; iwait = 0; dwait = 0; last_cyc = 0;
    for (int i = 0; i < 1024; i++) dmem[i] = '0;

    clear_imem();
    imem[0] = e_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);
    imem[1] = e_i(12'hFF9, 5'd1, 3'b000, 5'd2, 7'h13);
    run_prog("addi", 0, 0);
    check("addi_x1_abs", dut.u_rf.regs_q[1], 32'd5);
    check("addi_x2_abs", dut.u_rf.regs_q[2], 32'hFFFF_FFFE);
    check("addi_exit_cycle", last_cyc, 5);

    clear_imem();
    dmem[64] = 32'hDEAD_BEEF; dmem[65] = '0;
    imem[0] = e_i(12'h100, 5'd0, 3'b010, 5'd3, 7'h03);
    imem[1] = e_s(12'h104, 5'd3, 5'd0);
    run_prog("ldst", 0, 0);
    check("ldst_mem104", dmem[65], 32'hDEAD_BEEF);
    check("ldst_total_cycles", last_cyc, 7);

    dmem[65] = '0;
    run_prog("ldst_wait", 3, 2);
    check("ldst_wait_x3", dut.u_rf.regs_q[3], 32'hDEAD_BEEF);
    check("ldst_wait_cycles", last_cyc, 17);

    clear_imem();
    imem[0] = e_b(13'd8, 5'd0, 5'd0);
    run_prog("beq", 0, 0);
    check("beq_cycles", last_cyc, 3);

    clear_imem();
    run_prog("illegal", 1, 0);
    check("illegal_trap", 32'(trap), 32'd1);

    clear_imem();
    imem[0] = e_i(12'd7, 5'd0, 3'b000, 5'd5, 7'h13);
    imem[1] = e_i(12'h102, 5'd0, 3'b010, 5'd3, 7'h03);
    run_prog("misalign", 0, 0);
    check("misalign_cycles", last_cyc, 4);

    // Branch backwards from 0 lands on the top word; its pc+4 must wrap to 0.
    clear_imem();
    imem[0]    = e_b(13'(-4), 5'd0, 5'd1);
    imem[1023] = e_i(12'd1, 5'd1, 3'b000, 5'd1, 7'h13);
    imem[1]    = e_i(12'd3, 5'd0, 3'b000, 5'd2, 7'h13);
    run_prog("wrap", 0, 0);
    check("wrap_cycles", last_cyc, 9);

    clear_imem();
    dmem[64] = 32'h1234_5678;
    imem[0] = e_i(12'd9, 5'd0, 3'b000, 5'd1, 7'h13);
    imem[1] = e_i(12'h100, 5'd0, 3'b010, 5'd3, 7'h03);
    launch(0, 3);
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk); #1; found = dmem_req;
    end
    check("midrst_saw_dmem_req", 32'(found), 32'd1);
    check("midrst_x1_before", dut.u_rf.regs_q[1], 32'd9);
    #2 rst = 1;
    #1;
    check("midrst_dmem_req_drop", 32'(dmem_req), 32'd0);
    check("midrst_imem_req", 32'(imem_req), 32'd0);
    check("midrst_x1_cleared", dut.u_rf.regs_q[1], 32'd0);
    run_prog("after_rst", 0, 0);

    for (int t = 0; t < 6; t++) begin
      for (int w = 64; w < 128; w++) dmem[w] = $urandom;
      gen_random(16);
      run_prog($sformatf("rand%0d", t), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
